// File: rtl/pfb_pkg.sv
// Shared definitions for the PFB filter datapath.
//   ROUND_TRUNC / ROUND_HALF_UP : values of the ROUND_MODE parameter
//   clog2()                     : ceiling log2 for elaboration-time sizing
//   ch_width()                  : channel tag width, never narrower than 1 bit
package pfb_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/pfb_multichannel_mul_pipe_if.sv
// Sample/coefficient bus into the PFB coefficient multiplier and the
// product bus out of it towards the per-channel accumulator.
//   ce, in_valid, din0, din1, in_ch     : driven by the upstream source
//   out_valid, dout, out_ch, out_sat    : driven by the multiplier
// The upstream source owns the stall through ce; there is no backpressure.
interface pfb_multichannel_mul_pipe_if
  import pfb_pkg::*;
#(
  parameter int DIN0_WIDTH = 11,
  parameter int DIN1_WIDTH = 13,
  parameter int DOUT_WIDTH = 23,
  parameter int NUM_CH     = 8
);

  localparam int CH_WIDTH = ch_width(NUM_CH);

  logic                  ce;
  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic [CH_WIDTH-1:0]   in_ch;

  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic [CH_WIDTH-1:0]   out_ch;
  logic                  out_sat;

  modport master (
    output ce, in_valid, din0, din1, in_ch,
    input  out_valid, dout, out_ch, out_sat
  );

  modport slave (
    input  ce, in_valid, din0, din1, in_ch,
    output out_valid, dout, out_ch, out_sat
  );

endinterface

// File: rtl/pfb_round_sat.sv
// Combinational post-product unit: optional round-half-up, arithmetic right
// shift by SHIFT, then clip to a DOUT_WIDTH signed or unsigned range.
//   din   : exact signed product, IN_W bits
//   value : shifted/rounded/saturated result, DOUT_WIDTH bits
//   sat   : 1 when value was clipped
module pfb_round_sat
  import pfb_pkg::*;
#(
  parameter int IN_W       = 26,
  parameter int SHIFT      = 0,
  parameter int ROUND_MODE = ROUND_TRUNC,
  parameter int DOUT_WIDTH = 23,
  parameter int OUT_SIGNED = 0
) (
  input  logic signed [IN_W-1:0]       din,
  output logic        [DOUT_WIDTH-1:0] value,
  output logic                         sat
);

  // One guard bit so the rounding add can never wrap.
  localparam int XW = IN_W + 1;
  // Compare width wide enough for both the shifted value and the bounds.
  localparam int CW = ((XW > DOUT_WIDTH + 1) ? XW : DOUT_WIDTH + 1) + 1;
  // A product with IN_W - SHIFT significant bits always fits otherwise.
  localparam bit CAN_CLIP = (DOUT_WIDTH < IN_W - SHIFT);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [XW-1:0] RND =
    (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (XW'(1) <<< RSH) : '0;

  localparam logic signed [CW-1:0] HI = (OUT_SIGNED != 0) ?
    (CW'(1) <<< (DOUT_WIDTH - 1)) - CW'(1) :
    (CW'(1) <<< DOUT_WIDTH) - CW'(1);

  localparam logic signed [CW-1:0] LO = (OUT_SIGNED != 0) ?
    -(CW'(1) <<< (DOUT_WIDTH - 1)) : '0;

  function automatic logic signed [XW-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [XW-1:0] t;
    t = XW'(x) + RND;
    return t >>> SHIFT;
  endfunction

  // Returns {sat, value}.
  function automatic logic [DOUT_WIDTH:0] saturate(input logic signed [XW-1:0] x);
    logic signed [CW-1:0] w;
    w = CW'(x);
    if (CAN_CLIP && (w > HI)) return {1'b1, HI[DOUT_WIDTH-1:0]};
    if (CAN_CLIP && (w < LO)) return {1'b1, LO[DOUT_WIDTH-1:0]};
    return {1'b0, w[DOUT_WIDTH-1:0]};
  endfunction

  assign {sat, value} = saturate(round_shift(din));

endmodule

// File: rtl/pfb_multichannel_mul_pipe.sv
// Pipelined coefficient multiplier for the PFB filter datapath.
// Multiplies sample din0 by coefficient din1 (each with its own signedness),
// then shifts, optionally rounds and saturates the exact product to
// DOUT_WIDTH. A channel tag and valid bit travel with every sample.
// Ports:
//   ap_clk : clock, rising edge
//   ap_rst : synchronous active-high reset, clears valids and outputs
//   bus    : slave side of pfb_multichannel_mul_pipe_if
//            (ce, in_valid, din0, din1, in_ch in; out_valid, dout, out_ch,
//            out_sat out)
// Latency is NUM_STAGE enabled cycles; ce=0 freezes every register.
module pfb_multichannel_mul_pipe
  import pfb_pkg::*;
#(
  parameter int DIN0_WIDTH  = 11,
  parameter int DIN1_WIDTH  = 13,
  parameter int DOUT_WIDTH  = 23,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND_MODE  = ROUND_TRUNC,
  parameter int NUM_STAGE   = 2,
  parameter int NUM_CH      = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  pfb_multichannel_mul_pipe_if.slave   bus
);

  localparam int CH_WIDTH   = ch_width(NUM_CH);
  localparam int PW         = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int RES_SIGNED = (DIN0_SIGNED != 0 || DIN1_SIGNED != 0) ? 1 : 0;
  // Product registers: stage 1 plus NUM_STAGE-2 retiming stages.
  localparam int NPS        = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

  logic signed [DIN0_WIDTH:0] a_ext;
  logic signed [DIN1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       prod_c;

  // Both operands widen by one bit so mixed signedness multiplies as signed.
  always_comb begin
    a_ext  = (DIN0_SIGNED != 0) ? {bus.din0[DIN0_WIDTH-1], bus.din0} : {1'b0, bus.din0};
    b_ext  = (DIN1_SIGNED != 0) ? {bus.din1[DIN1_WIDTH-1], bus.din1} : {1'b0, bus.din1};
    prod_c = PW'(a_ext) * PW'(b_ext);
  end

  logic signed [PW-1:0]    rs_in;
  logic                    rs_vld;
  logic [CH_WIDTH-1:0]     rs_ch;
  logic [DOUT_WIDTH-1:0]   rs_val;
  logic                    rs_sat;

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign rs_in  = prod_c;
      assign rs_vld = bus.in_valid;
      assign rs_ch  = bus.in_ch;
    end else begin : g_prod
      logic signed [PW-1:0] prod_p [NPS];
      logic                 vld_p  [NPS];
      logic [CH_WIDTH-1:0]  ch_p   [NPS];

      // ---- stage 1: full product, then retiming stages ahead of rounding ----
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < NPS; i++) vld_p[i] <= 1'b0;
        end else if (bus.ce) begin
          vld_p[0] <= bus.in_valid;
          for (int i = 1; i < NPS; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge ap_clk) begin
        if (bus.ce) begin
          prod_p[0] <= prod_c;
          ch_p[0]   <= bus.in_ch;
          for (int i = 1; i < NPS; i++) begin
            prod_p[i] <= prod_p[i-1];
            ch_p[i]   <= ch_p[i-1];
          end
        end
      end

      assign rs_in  = prod_p[NPS-1];
      assign rs_vld = vld_p[NPS-1];
      assign rs_ch  = ch_p[NPS-1];
    end
  endgenerate

  pfb_round_sat #(
    .IN_W       (PW),
    .SHIFT      (SHIFT),
    .ROUND_MODE (ROUND_MODE),
    .DOUT_WIDTH (DOUT_WIDTH),
    .OUT_SIGNED (RES_SIGNED)
  ) u_round_sat (
    .din   (rs_in),
    .value (rs_val),
    .sat   (rs_sat)
  );

  logic                  vld_pout;
  logic [DOUT_WIDTH-1:0] dout_pout;
  logic [CH_WIDTH-1:0]   ch_pout;
  logic                  sat_pout;

  // ---- final stage: registered round/shift/saturate result ----
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_pout  <= 1'b0;
      dout_pout <= '0;
      ch_pout   <= '0;
      sat_pout  <= 1'b0;
    end else if (bus.ce) begin
      vld_pout  <= rs_vld;
      dout_pout <= rs_val;
      ch_pout   <= rs_ch;
      sat_pout  <= rs_sat;
    end
  end

  assign bus.out_valid = vld_pout;
  assign bus.dout      = dout_pout;
  assign bus.out_ch    = ch_pout;
  assign bus.out_sat   = sat_pout;

endmodule

// File: doc/pfb_multichannel_mul_pipe.md
Name: pfb_multichannel_mul_pipe

Overview:
Parametrised, pipelined coefficient multiplier for the PFB filter datapath. It is the next generation of the fixed-width combinational `mul_*` cores and adds the following: per-operand signedness, programmable latency, a post-product shift with optional rounding, and saturation to the output width. It also passes a channel tag and a valid bit through the pipeline. It sits between the coefficient ROM/sample delay lines and the per-channel accumulator, and stalls via a clock enable.

Parameters:
DIN0_WIDTH, 11, width of operand din0 (sample)
DIN1_WIDTH, 13, width of operand din1 (coefficient)
DOUT_WIDTH, 23, width of dout
DIN0_SIGNED, 0, 1 = din0 is two's complement, 0 = unsigned
DIN1_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned
SHIFT, 0, right-shift applied to the full product before output, range 0..DIN0_WIDTH+DIN1_WIDTH-1
ROUND_MODE, 0, 0 = truncate (floor), 1 = round half up
NUM_STAGE, 2, latency in enabled cycles, range 1..4
NUM_CH, 8, channel count; CH_WIDTH = max(1, clog2(NUM_CH))

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  synchronous reset, active high
ce  in  1  pipeline clock enable; 0 freezes all stages
in_valid  in  1  din0/din1/in_ch are valid this cycle
din0  in  DIN0_WIDTH  sample operand
din1  in  DIN1_WIDTH  coefficient operand
in_ch  in  CH_WIDTH  channel tag, carried with the data
out_valid  out  1  dout/out_ch/out_sat are valid
dout  out  DOUT_WIDTH  shifted, rounded and saturated product
out_ch  out  CH_WIDTH  channel tag of dout
out_sat  out  1  dout was clipped this sample

Behaviour:
- Reset (one synchronous cycle with ap_rst=1, independent of ce):
  - all stage valid bits clear to 0
  - out_valid=0, dout=0, out_ch=0, out_sat=0
  - data in flight is discarded; the first new output appears NUM_STAGE enabled cycles after the first post-reset accept.
- Accept: a sample is captured on a rising edge when ce=1. The stage-0 valid bit loads in_valid. Data registers load regardless of in_valid; their value does not matter when valid=0.
- ce=0: every register holds, including the valid bits and the outputs. Outputs stay stable for as long as ce is low. The block has no backpressure output; the upstream source owns the stall.
- Latency: a sample accepted at enabled edge k appears on the outputs after enabled edge k+NUM_STAGE-1. With ce held high the pipeline runs at full throughput, one sample per cycle.
- Pipeline stages:
  - Stage 1 registers the full product.
  - The final stage registers the round, shift and saturate result.
  - When NUM_STAGE=1, everything sits in one register stage.
  - When NUM_STAGE>2, the extra stages are retiming registers between product and round. They are placed ahead of the round logic so synthesis can absorb them into the DSP.
- Arithmetic:
  - Each operand is extended by 1 bit according to its own signedness flag.
  - The product is a signed value of PW = DIN0_WIDTH+DIN1_WIDTH+2 bits and is exact.
  - The result is signed if DIN0_SIGNED or DIN1_SIGNED is set, unsigned otherwise.
- Round and shift:
  - ROUND_MODE=0 gives an arithmetic shift right by SHIFT, which is floor.
  - ROUND_MODE=1 with SHIFT>0 adds 2^(SHIFT-1) first, then shifts. There is no overflow from the add, because the intermediate is PW+1 bits.
  - SHIFT=0 ignores ROUND_MODE.
- Saturation:
  - Signed result: clip to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - Unsigned result: clip to [0, 2^DOUT_WIDTH-1].
  - out_sat=1 exactly when the value was clipped.
  - If DOUT_WIDTH ≥ PW-SHIFT, clipping is impossible and out_sat is tied 0.
- out_ch is always the in_ch that was accepted with the same sample.
- out_valid=0 samples still update dout and out_ch. Consumers must qualify on out_valid.

Decomposition:
- Shared package pfb_pkg holds:
  - the ROUND_TRUNC=0 and ROUND_HALF_UP=1 constants
  - the clog2 function
  - the CH_WIDTH derivation
- One sub-module, pfb_round_sat: a combinational round, shift and saturate unit. It is parametrised by input width, SHIFT, ROUND_MODE, DOUT_WIDTH and signedness, and has outputs value and sat. The top level holds the multiply, the stage registers and the valid/tag pipeline.

Test Plan:
- Unsigned saturation (defaults, NUM_STAGE=2). din0=2047, din1=8191, in_ch=5, valid → 2 cycles later out_valid=1, dout=8388607 (true product 16766977), out_sat=1, out_ch=5. Then din0=100, din1=200 → dout=20000, out_sat=0.
- Signed (DIN0_SIGNED=DIN1_SIGNED=1). din0=-1024, din1=4095 → dout=-4193280, out_sat=0. din0=-1024, din1=-4096 → product 4194304, so dout=4194303, out_sat=1.
- Rounding (signed, SHIFT=4). Products 24, 23 and -23 must give:
  - ROUND_MODE=1: dout 2, 1, -1
  - ROUND_MODE=0: dout 1, 1, -2
- ce stall (NUM_STAGE=3). Stream ch 0..7 with ce high, drop ce for 4 cycles mid-stream, then restore it. Required:
  - outputs frozen during the stall
  - no sample lost or duplicated
  - per-sample latency of 3 enabled cycles
  - tags in order
- Reset mid-stream. Assert ap_rst for 1 cycle with ce=0 while 2 samples are in flight. Next cycle: out_valid=0, dout=0. The in-flight samples never appear, and the first post-reset sample emerges after NUM_STAGE enabled cycles.
- Back-to-back random (all parameter corners, NUM_STAGE 1..4). Drive 10k random operands with random in_valid and ce. A scoreboard with an exact reference model must match dout, out_sat and out_ch on every out_valid.
